seg7_scan: RTL and testbench

- Multiplexed 7-segment display driver. Sits directly downstream of the clock divider and consumes its ~190 Hz scan output as the digit-scan rate.
- Displays NDIG BCD digits, one per scan tick, on a common-anode display. Uses active-low anodes, segments and decimal point.
- scan_clk is treated as data: synchronised and edge-detected into a single-cycle enable in the clk domain. It is never used as a clock.

---
 rtl/seg7_scan_pkg.sv | 38 +++
 rtl/seg7_scan_tick_sync.sv | 35 +++
 rtl/seg7_scan.sv | 136 +++++++++++++
 tb/tb_seg7_scan.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// seg7_pkg: shared segment encodings and the BCD-to-segment decoder for the
//   multiplexed 7-segment display driver.
// Encodings are active-low {a,b,c,d,e,f,g} = seg[6:0] for a common-anode display.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-BCD nibbles (A-F) show a dash so bad data is visible rather than hidden.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_tick_sync.sv
// tick_sync: synchronises a slow asynchronous level (e.g. a clock-divider output)
//   into clk and emits a single-cycle pulse on each of its rising edges.
// Latency: tick is high during the cycle after the SYNC_STAGES-th sampling edge.
// Ports: clk, clr (async, active-high), async_in (raw level), tick (1-clk pulse).
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // Rising edge of the synchronised level only; falling edges are ignored.
  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed common-anode 7-segment driver, one digit per scan tick,
//   with a per-frame shadow of the inputs so a frame never shows mixed data.
// Latency: outputs update on the clk edge after the synchronised scan tick;
//   there is no backpressure, inputs are simply sampled at each frame wrap.
// Ports: clk, clr (async, active-high), scan_clk (sampled as data), bcd_in,
//   dp_in, blank_lz in; an, seg, dp (all active-low) and frame_done out.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              scan_clk,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lz,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_done
);

  localparam int               IDX_W = $clog2(NDIG);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NDIG - 1);

  logic tick;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk     (clk),
    .clr     (clr),
    .async_in(scan_clk),
    .tick    (tick)
  );

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] digs_q, digs_d;
  logic [NDIG-1:0]   dps_q, dps_d;
  logic              blz_q, blz_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_done_q, frame_done_d;

  // lz_vec[i]: shadow digit i and every more-significant digit are zero.
  // Digit 0 is never a leading zero, so bit 0 stays clear.
  logic [NDIG-1:0] lz_vec;
  logic            zero_run;

  always_comb begin
    lz_vec   = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run  = zero_run & (digs_q[4*i +: 4] == 4'h0);
      lz_vec[i] = zero_run;
    end
  end

  logic [3:0] nib;
  logic       sel_dp;
  logic       blank;

  always_comb begin
    idx_d        = idx_q;
    digs_d       = digs_q;
    dps_d        = dps_q;
    blz_d        = blz_q;
    an_d         = an_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;
    nib          = 4'h0;
    sel_dp       = 1'b0;
    blank        = 1'b0;

    if (tick) begin
      if (idx_q == LAST) begin
        // Frame wrap: latch a fresh frame and show digit 0 straight from the
        // inputs, since the shadow is only being written on this edge.
        idx_d        = '0;
        digs_d       = bcd_in;
        dps_d        = dp_in;
        blz_d        = blank_lz;
        frame_done_d = 1'b1;
        nib          = bcd_in[3:0];
        sel_dp       = dp_in[0];
      end else begin
        idx_d = idx_q + 1'b1;
        for (int i = 1; i < NDIG; i++) begin
          if (IDX_W'(i) == idx_d) begin
            nib    = digs_q[4*i +: 4];
            sel_dp = dps_q[i];
            blank  = blz_q & lz_vec[i];
          end
        end
      end

      for (int i = 0; i < NDIG; i++) begin
        an_d[i] = (IDX_W'(i) != idx_d);
      end
      seg_d = blank ? SEG_BLANK : bcd_to_seg(nib);
      dp_d  = ~sel_dp;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      idx_q        <= LAST;
      digs_q       <= '0;
      dps_q        <= '0;
      blz_q        <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      digs_q       <= digs_d;
      dps_q        <= dps_d;
      blz_q        <= blz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        scan_clk = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_scan #(
    .NDIG       (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .scan_clk  (scan_clk),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  // Hand-computed active-low segment patterns.
  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] PD = 7'b1111110;
  localparam logic [6:0] PB = 7'b1111111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full scan_clk period; counts frame_done pulses seen on the way.
  task automatic pulse(output int fd);
    fd = 0;
    @(negedge clk) scan_clk = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd++;
    end
    scan_clk = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd++;
    end
  endtask

  // Four ticks starting at a frame wrap; expected digits given msd first.
  task automatic run_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpn);
    logic [6:0] se [4];
    logic [3:0] ane [4];
    int fd;
    se[0] = s0; se[1] = s1; se[2] = s2; se[3] = s3;
    ane[0] = 4'b1110; ane[1] = 4'b1101; ane[2] = 4'b1011; ane[3] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      pulse(fd);
      chk($sformatf("%s an d%0d", tag, i), 32'(an), 32'(ane[i]));
      chk($sformatf("%s seg d%0d", tag, i), 32'(seg), 32'(se[i]));
      chk($sformatf("%s dp d%0d", tag, i), 32'(dp), 32'(dpn[i]));
      chk($sformatf("%s frame_done d%0d", tag, i), 32'(fd), (i == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int fd;
    int changes;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst an", 32'(an), 32'hF);
    chk("rst seg", 32'(seg), 32'h7F);
    chk("rst dp", 32'(dp), 32'd1);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // First tick latency: sampled at edge 1, tick after edge 2, outputs at edge 3.
    bcd_in = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0;
    scan_clk = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat an before edge3", 32'(an), 32'hF);
    @(negedge clk);
    chk("lat an at edge3", 32'(an), 32'b1110);
    chk("lat seg at edge3", 32'(seg), 32'(P4));
    chk("lat frame_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("lat frame_done one cycle", 32'(frame_done), 32'd0);
    repeat (4) @(negedge clk);
    scan_clk = 1'b0;
    repeat (6) @(negedge clk);
    // Finish that frame (idx now 0).
    pulse(fd); chk("f1 seg d1", 32'(seg), 32'(P3));
    pulse(fd); chk("f1 seg d2", 32'(seg), 32'(P2));
    pulse(fd); chk("f1 seg d3", 32'(seg), 32'(P1));
    chk("f1 an d3", 32'(an), 32'b0111);

    run_frame("1234", P1, P2, P3, P4, 4'b1111);

    bcd_in = 16'h0050; blank_lz = 1'b1;
    run_frame("0050 lz", PB, PB, P5, P0, 4'b1111);

    bcd_in = 16'h0000; blank_lz = 1'b1; dp_in = 4'b0100;
    run_frame("0000 lz dp", PB, PB, PB, P0, 4'b1011);

    bcd_in = 16'h00A0; blank_lz = 1'b0; dp_in = 4'b0000;
    run_frame("00A0", P0, P0, PD, P0, 4'b1111);

    blank_lz = 1'b1;
    run_frame("00A0 lz", PB, PB, PD, P0, 4'b1111);

    // No tearing: inputs change mid-frame, visible only after next wrap.
    bcd_in = 16'h1111; blank_lz = 1'b0;
    pulse(fd); chk("tear d0 seg", 32'(seg), 32'(P1));
    pulse(fd); chk("tear d1 seg", 32'(seg), 32'(P1));
    bcd_in = 16'h2222; blank_lz = 1'b1;
    pulse(fd); chk("tear d2 seg", 32'(seg), 32'(P1));
    pulse(fd); chk("tear d3 seg", 32'(seg), 32'(P1));
    chk("tear d3 frame_done", 32'(fd), 32'd0);
    run_frame("2222", P2, P2, P2, P2, 4'b1111);

    // clr mid-frame: dark immediately, dark while scan_clk idle, then wrap.
    bcd_in = 16'h1234; blank_lz = 1'b0;
    pulse(fd); pulse(fd); pulse(fd);
    chk("pre-clr an", 32'(an), 32'b1011);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr an async", 32'(an), 32'hF);
    chk("clr seg async", 32'(seg), 32'h7F);
    chk("clr dp async", 32'(dp), 32'd1);
    changes = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 500) clr = 1'b0;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) changes++;
    end
    chk("idle 1000 clk output changes", 32'(changes), 32'd0);
    pulse(fd);
    chk("post-clr an", 32'(an), 32'b1110);
    chk("post-clr seg", 32'(seg), 32'(P4));
    chk("post-clr frame_done", 32'(fd), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

endmodule
